controller: RTL and testbench
=============================

// Module: controller
// PURPOSE
//  Multicycle MIPS control unit: a Moore FSM (main decoder) plus a combinational ALU decoder.
//  Decodes op/funct and sequences datapath enables for LW, SW, R-type, BEQ, ADDI and J.
//  Sits beside the multicycle datapath (shared instr/data memory, IR, A/B, ALUOut registers).
// PARAMETERS
//  none (all encodings below are fixed)
// PORTS
//  clk         in   1  clock; all state updates on the rising edge
//  reset       in   1  synchronous, active-high; forces FSM to FETCH
//  op          in   6  instruction opcode, IR[31:26]
//  funct       in   6  R-type function field, IR[5:0]
//  zero        in   1  ALU zero flag, used for BEQ
//  pcen        out  1  PC write enable = pcwrite | (branch & zero)
//  memwrite    out  1  memory write strobe
//  irwrite     out  1  instruction register load
//  regwrite    out  1  register file write
//  alusrca     out  1  0: PC, 1: register A
//  iord        out  1  0: address from PC, 1: address from ALUOut
//  memtoreg    out  1  0: ALUOut, 1: memory data to register file
//  regdst      out  1  0: rt, 1: rd as write register
//  alusrcb     out  2  00: B, 01: constant 4, 10: SignImm, 11: SignImm<<2
//  pcsrc       out  2  00: ALUResult, 01: ALUOut, 10: jump target
//  alucontrol  out  4  ALU operation select
// BEHAVIOUR
//  - State register: 4 bits, rising edge. reset=1 at an edge loads FETCH.
//  - States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
//  - Transitions: FETCH->DECODE.
//  - DECODE branches on op: 100011 LW or 101011 SW -> MEMADR; 000000 -> RTYPEEX;
//    000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX; any other op -> FETCH.
//  - MEMADR->MEMRD if op=LW, else MEMWR.
//  - MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB.
//  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB and JEX all -> FETCH. Unused encodings -> FETCH.
//  - Outputs are Moore (a function of state only), except pcen, which also uses zero.
//    Every signal not listed for a state is 0, including 2-bit fields = 00.
//    FETCH:   iord=0 alusrca=0 alusrcb=01 aluop=00 pcsrc=00 irwrite=1 pcwrite=1
//    DECODE:  alusrca=0 alusrcb=11 aluop=00
//    MEMADR:  alusrca=1 alusrcb=10 aluop=00
//    MEMRD:   iord=1
//    MEMWB:   regdst=0 memtoreg=1 regwrite=1
//    MEMWR:   iord=1 memwrite=1
//    RTYPEEX: alusrca=1 alusrcb=00 aluop=10
//    RTYPEWB: regdst=1 memtoreg=0 regwrite=1
//    BEQEX:   alusrca=1 alusrcb=00 aluop=01 pcsrc=01 branch=1
//    ADDIEX:  alusrca=1 alusrcb=10 aluop=00
//    ADDIWB:  regdst=0 memtoreg=0 regwrite=1
//    JEX:     pcsrc=10 pcwrite=1
//  - ALU decoder (combinational, aluop is internal 2-bit):
//    aluop 00 -> 0010 (add); 01 -> 0110 (sub); 11 -> 0010.
//    aluop 10 by funct: 100000 -> 0010 add, 100010 -> 0110 sub, 100100 -> 0000 and,
//    100101 -> 0001 or, 101010 -> 0111 slt, 100111 -> 1100 nor, other -> 0000.
//  - After reset, outputs are the FETCH values: pcen=1, irwrite=1, alusrcb=01, alucontrol=0010.
//  - Reset asserted mid-instruction: next edge goes to FETCH and the instruction is abandoned.
//  - X or Z on funct or zero must not disturb the FSM; they only affect alucontrol and pcen.
//  - Latency per instruction in cycles: LW 5; SW 4; R-type 4; ADDI 4; BEQ 3; J 3.
// TESTING
//  - reset high across 1 edge, op=100011 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH;
//    MEMWB: regwrite=1 memtoreg=1 regdst=0.
//  - op=101011 -> MEMWR (memwrite=1, iord=1) in cycle 4, then FETCH; regwrite stays 0 throughout.
//  - op=000000 funct=100000 -> RTYPEEX: alucontrol=0010, alusrca=1;
//    RTYPEWB: regwrite=1, regdst=1.
//    Repeat RTYPEEX with funct=100010 -> 0110 and funct=101010 -> 0111.
//  - op=000100: BEQEX with zero=1 -> pcen=1 pcsrc=01 alucontrol=0110;
//    BEQEX with zero=0 -> pcen=0.
//  - op=001000 -> ADDIEX alusrcb=10 alucontrol=0010, then ADDIWB regwrite=1 regdst=0;
//    op=000010 -> JEX pcen=1 pcsrc=10.
//  - Assert reset during MEMRD -> FETCH at the next edge. Illegal op 111111 -> DECODE, then FETCH.

Source files
------------

// File: rtl/controller_if.sv
// ============================================================================
//  Module      : controller_if
//  Description : Control bus between the multicycle MIPS controller and its
//                datapath: instruction fields and flags in, enables out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [3:0] alucontrol;

    modport master (
        input  op, funct, zero,
        output pcen, memwrite, irwrite, regwrite, alusrca, iord,
               memtoreg, regdst, alusrcb, pcsrc, alucontrol
    );

    modport slave (
        output op, funct, zero,
        input  pcen, memwrite, irwrite, regwrite, alusrca, iord,
               memtoreg, regdst, alusrcb, pcsrc, alucontrol
    );
endinterface

`default_nettype wire

// File: rtl/controller.sv
// ============================================================================
//  Module      : controller
//  Description : Multicycle MIPS control unit - Moore main-decoder FSM plus a
//                combinational ALU decoder (LW, SW, R-type, BEQ, ADDI, J).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controller (
    input  wire              clk,
    input  wire              reset,
    controller_if.master     ctl
);

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic       w_pcwrite;
    logic       w_branch;
    logic [1:0] w_aluop;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_alusrca;
    logic       w_iord;
    logic       w_memtoreg;
    logic       w_regdst;
    logic [1:0] w_alusrcb;
    logic [1:0] w_pcsrc;
    logic [3:0] w_alucontrol;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= FETCH;
        else
            r_state <= w_next_state;
    end

    // Next state depends on op only, so X/Z on funct or zero cannot reach it.
    always_comb begin
        w_next_state = FETCH;
        case (r_state)
            FETCH:   w_next_state = DECODE;
            DECODE: begin
                case (ctl.op)
                    OP_LW, OP_SW: w_next_state = MEMADR;
                    OP_RTYPE:     w_next_state = RTYPEEX;
                    OP_BEQ:       w_next_state = BEQEX;
                    OP_ADDI:      w_next_state = ADDIEX;
                    OP_J:         w_next_state = JEX;
                    default:      w_next_state = FETCH;
                endcase
            end
            MEMADR:  w_next_state = (ctl.op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   w_next_state = MEMWB;
            RTYPEEX: w_next_state = RTYPEWB;
            ADDIEX:  w_next_state = ADDIWB;
            default: w_next_state = FETCH;
        endcase
    end

    always_comb begin
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_aluop    = 2'b00;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_alusrca  = 1'b0;
        w_iord     = 1'b0;
        w_memtoreg = 1'b0;
        w_regdst   = 1'b0;
        w_alusrcb  = 2'b00;
        w_pcsrc    = 2'b00;
        case (r_state)
            FETCH: begin
                w_alusrcb = 2'b01;
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
            end
            DECODE:  w_alusrcb = 2'b11;
            MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            MEMRD:   w_iord = 1'b1;
            MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
            end
            MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
            end
            RTYPEEX: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
            end
            RTYPEWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
            end
            BEQEX: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b01;
                w_pcsrc   = 2'b01;
                w_branch  = 1'b1;
            end
            ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            ADDIWB:  w_regwrite = 1'b1;
            JEX: begin
                w_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_alucontrol = ALU_ADD;
        case (w_aluop)
            2'b01: w_alucontrol = ALU_SUB;
            2'b10: begin
                case (ctl.funct)
                    6'b100000: w_alucontrol = ALU_ADD;
                    6'b100010: w_alucontrol = ALU_SUB;
                    6'b100100: w_alucontrol = ALU_AND;
                    6'b100101: w_alucontrol = ALU_OR;
                    6'b101010: w_alucontrol = ALU_SLT;
                    6'b100111: w_alucontrol = ALU_NOR;
                    default:   w_alucontrol = ALU_AND;
                endcase
            end
            default: w_alucontrol = ALU_ADD;
        endcase
    end

    assign ctl.pcen       = w_pcwrite | (w_branch & ctl.zero);
    assign ctl.memwrite   = w_memwrite;
    assign ctl.irwrite    = w_irwrite;
    assign ctl.regwrite   = w_regwrite;
    assign ctl.alusrca    = w_alusrca;
    assign ctl.iord       = w_iord;
    assign ctl.memtoreg   = w_memtoreg;
    assign ctl.regdst     = w_regdst;
    assign ctl.alusrcb    = w_alusrcb;
    assign ctl.pcsrc      = w_pcsrc;
    assign ctl.alucontrol = w_alucontrol;

endmodule

`default_nettype wire

// File: tb/tb_controller.sv
// ============================================================================
//  Module      : tb_controller
//  Description : Directed scoreboard bench for the multicycle MIPS controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controller;

    logic clk = 1'b0;
    logic reset;
    controller_if bus ();

    controller dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus.master)
    );

    always #5 clk = ~clk;

    // Packed order: pcen memwrite irwrite regwrite alusrca iord memtoreg regdst
    //               | alusrcb | pcsrc | alucontrol
    localparam logic [15:0] E_FETCH  = {8'b1010_0000, 2'b01, 2'b00, 4'b0010};
    localparam logic [15:0] E_DECODE = {8'b0000_0000, 2'b11, 2'b00, 4'b0010};
    localparam logic [15:0] E_MEMADR = {8'b0000_1000, 2'b10, 2'b00, 4'b0010};
    localparam logic [15:0] E_MEMRD  = {8'b0000_0100, 2'b00, 2'b00, 4'b0010};
    localparam logic [15:0] E_MEMWB  = {8'b0001_0010, 2'b00, 2'b00, 4'b0010};
    localparam logic [15:0] E_MEMWR  = {8'b0100_0100, 2'b00, 2'b00, 4'b0010};
    localparam logic [15:0] E_RTWB   = {8'b0001_0001, 2'b00, 2'b00, 4'b0010};
    localparam logic [15:0] E_ADDIEX = {8'b0000_1000, 2'b10, 2'b00, 4'b0010};
    localparam logic [15:0] E_ADDIWB = {8'b0001_0000, 2'b00, 2'b00, 4'b0010};
    localparam logic [15:0] E_JEX    = {8'b1000_0000, 2'b00, 2'b10, 4'b0010};
    localparam logic [15:0] E_BEQ_Z1 = {8'b1000_1000, 2'b00, 2'b01, 4'b0110};
    localparam logic [15:0] E_BEQ_Z0 = {8'b0000_1000, 2'b00, 2'b01, 4'b0110};

    function automatic logic [15:0] e_rtex(input logic [3:0] alu);
        return {8'b0000_1000, 2'b00, 2'b00, alu};
    endfunction

    typedef struct {
        string       name;
        logic [15:0] exp;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;

    wire [15:0] actual = {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite,
                          bus.alusrca, bus.iord, bus.memtoreg, bus.regdst,
                          bus.alusrcb, bus.pcsrc, bus.alucontrol};

    // Each cycle's expectation is pushed just after the edge; sample at negedge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            it = q.pop_front();
            checks++;
            if (actual !== it.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h (t=%0t)", it.name, actual, it.exp, $time);
            end
        end
    end

    task automatic step(input string name, input logic [15:0] exp);
        item_t it;
        @(posedge clk);
        #1;
        it.name = name;
        it.exp  = exp;
        q.push_back(it);
    endtask

    task automatic set_in(input logic [5:0] op, input logic [5:0] funct, input logic zero);
        bus.op    = op;
        bus.funct = funct;
        bus.zero  = zero;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        set_in(6'b100011, 6'b000000, 1'b0);
        step("reset_fetch", E_FETCH);
        reset = 1'b0;

        // LW: 5 cycles
        step("lw_decode", E_DECODE);
        step("lw_memadr", E_MEMADR);
        step("lw_memrd",  E_MEMRD);
        step("lw_memwb",  E_MEMWB);
        step("lw_fetch",  E_FETCH);

        // SW: 4 cycles
        set_in(6'b101011, 6'b000000, 1'b0);
        step("sw_decode", E_DECODE);
        step("sw_memadr", E_MEMADR);
        step("sw_memwr",  E_MEMWR);
        step("sw_fetch",  E_FETCH);

        // R-type add, sub, slt, nor
        set_in(6'b000000, 6'b100000, 1'b0);
        step("add_decode", E_DECODE);
        step("add_rtex",   e_rtex(4'b0010));
        step("add_rtwb",   E_RTWB);
        step("add_fetch",  E_FETCH);
        set_in(6'b000000, 6'b100010, 1'b0);
        step("sub_decode", E_DECODE);
        step("sub_rtex",   e_rtex(4'b0110));
        step("sub_rtwb",   E_RTWB);
        step("sub_fetch",  E_FETCH);
        set_in(6'b000000, 6'b101010, 1'b0);
        step("slt_decode", E_DECODE);
        step("slt_rtex",   e_rtex(4'b0111));
        step("slt_rtwb",   E_RTWB);
        step("slt_fetch",  E_FETCH);
        set_in(6'b000000, 6'b100111, 1'b0);
        step("nor_decode", E_DECODE);
        step("nor_rtex",   e_rtex(4'b1100));
        step("nor_rtwb",   E_RTWB);
        step("nor_fetch",  E_FETCH);

        // BEQ taken and not taken: 3 cycles each
        set_in(6'b000100, 6'b000000, 1'b1);
        step("beq1_decode", E_DECODE);
        step("beq1_ex",     E_BEQ_Z1);
        step("beq1_fetch",  E_FETCH);
        set_in(6'b000100, 6'b000000, 1'b0);
        step("beq0_decode", E_DECODE);
        step("beq0_ex",     E_BEQ_Z0);
        step("beq0_fetch",  E_FETCH);

        // ADDI with unknown funct, J with unknown zero
        set_in(6'b001000, 6'bxxxxxx, 1'b0);
        step("addi_decode", E_DECODE);
        step("addi_ex",     E_ADDIEX);
        step("addi_wb",     E_ADDIWB);
        step("addi_fetch",  E_FETCH);
        set_in(6'b000010, 6'b000000, 1'bx);
        step("j_decode", E_DECODE);
        step("j_ex",     E_JEX);
        bus.zero = 1'b0;
        step("j_fetch",  E_FETCH);

        // Reset during MEMRD abandons the load
        set_in(6'b100011, 6'b000000, 1'b0);
        step("rst_decode", E_DECODE);
        step("rst_memadr", E_MEMADR);
        step("rst_memrd",  E_MEMRD);
        reset = 1'b1;
        step("rst_fetch",  E_FETCH);
        reset = 1'b0;

        // Illegal opcode returns to FETCH after DECODE
        set_in(6'b111111, 6'b000000, 1'b0);
        step("ill_decode", E_DECODE);
        step("ill_fetch",  E_FETCH);
        set_in(6'b000000, 6'b000000, 1'b0);
        step("after_ill_decode", E_DECODE);

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
